// File: rtl/max_pooling_layer_if.sv
// Pixel stream bundle for the pooling stage: raster input pixels in and pooled pixels out.
// Each channel is D_WIDTH bits wide, packed with channel 0 in the low bits.
interface max_pooling_layer_if #(
  parameter int D_WIDTH  = 8,
  parameter int CHANNELS = 2
);
  logic                        input_valid;
  logic [D_WIDTH*CHANNELS-1:0] input_data;
  logic [D_WIDTH*CHANNELS-1:0] output_data;
  logic                        valid;

  modport master (output input_valid, input_data, input output_data, valid);
  modport slave  (input input_valid, input_data, output output_data, valid);
endinterface

// File: rtl/max_pooling_layer.sv
// Streaming non-overlapping POOL_SIZE x POOL_SIZE signed max pooling.
// Only one row of partial window maxima is kept per channel, not full lines.
module max_pooling_lane #(
  parameter int D_WIDTH = 8,
  parameter int NW      = 2,
  parameter int WX_W    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      acc,
  input  logic                      px_first,
  input  logic                      px_last,
  input  logic                      phase_first,
  input  logic                      phase_last,
  input  logic [WX_W-1:0]           wx,
  input  logic signed [D_WIDTH-1:0] din,
  output logic signed [D_WIDTH-1:0] dout
);
  logic signed [D_WIDTH-1:0] hmax, h, prow, m;
  logic signed [D_WIDTH-1:0] pbuf [NW];

  assign h    = (px_first || din > hmax) ? din : hmax;
  assign prow = pbuf[wx];
  assign m    = (prow > h) ? prow : h;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hmax <= '0;
      dout <= '0;
    end else if (acc) begin
      hmax <= h;
      if (px_last && phase_last) dout <= m;
    end
  end

  // No reset: the FIRST row always overwrites an entry before it is read.
  always_ff @(posedge clk) begin
    if (rst_n && acc && px_last && !phase_last)
      pbuf[wx] <= phase_first ? h : m;
  end
endmodule

module max_pooling_layer #(
  parameter int D_WIDTH    = 8,
  parameter int CHANNELS   = 2,
  parameter int IMAGE_SIZE = 4,
  parameter int POOL_SIZE  = 2
) (
  input logic            clk,
  input logic            rst_n,
  input logic            clk_en,
  max_pooling_layer_if.slave bus
);
  localparam int NW   = IMAGE_SIZE / POOL_SIZE;
  localparam int PX_W = $clog2(POOL_SIZE);
  localparam int WX_W = (NW > 1) ? $clog2(NW) : 1;

  if (POOL_SIZE < 2 || IMAGE_SIZE % POOL_SIZE != 0) begin : g_bad_cfg
    $error("max_pooling_layer: IMAGE_SIZE must be a multiple of POOL_SIZE >= 2");
  end

  typedef enum logic [1:0] {FIRST, MID, LAST} phase_t;
  phase_t phase;

  logic [PX_W-1:0] px, py;
  logic [WX_W-1:0] wx, wy;
  logic            acc, px_last, wx_last, py_last, wy_last;
  logic [CHANNELS-1:0][D_WIDTH-1:0] pix, pooled;

  assign acc     = clk_en & bus.input_valid;
  assign px_last = (px == PX_W'(POOL_SIZE - 1));
  assign py_last = (py == PX_W'(POOL_SIZE - 1));
  assign wx_last = (wx == WX_W'(NW - 1));
  assign wy_last = (wy == WX_W'(NW - 1));
  assign pix     = bus.input_data;
  assign bus.output_data = pooled;

  // Carry chain px -> wx -> py -> wy; phase tracks py so lanes need no compare.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      px        <= '0;
      wx        <= '0;
      py        <= '0;
      wy        <= '0;
      phase     <= FIRST;
      bus.valid <= 1'b0;
    end else if (clk_en) begin
      bus.valid <= acc && px_last && (phase == LAST);
      if (acc) begin
        px <= px_last ? '0 : px + 1'b1;
        if (px_last) begin
          wx <= wx_last ? '0 : wx + 1'b1;
          if (wx_last) begin
            py <= py_last ? '0 : py + 1'b1;
            if (py_last) begin
              phase <= FIRST;
              wy    <= wy_last ? '0 : wy + 1'b1;
            end else begin
              phase <= (py == PX_W'(POOL_SIZE - 2)) ? LAST : MID;
            end
          end
        end
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    max_pooling_lane #(.D_WIDTH(D_WIDTH), .NW(NW), .WX_W(WX_W)) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .acc        (acc),
      .px_first   (px == '0),
      .px_last    (px_last),
      .phase_first(phase == FIRST),
      .phase_last (phase == LAST),
      .wx         (wx),
      .din        (pix[c]),
      .dout       (pooled[c])
    );
  end
endmodule
